// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer between two single-word requesters and the 64x32 data memory.
// Each grant takes three cycles (IDLE sample, ACCESS, DONE); every output is driven from a register.
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData0,
    output logic [DATA_W-1:0] RData1,
    output logic              Busy,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_r;
    logic   last_grant_r;
    logic   cur_port_r;
    logic   cur_we_r;

    logic              any_req_s;
    logic              winner_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    // Winner selection: a lone requester wins, contention goes to the port not granted last.
    always_comb begin
        any_req_s = Req0 | Req1;
        if (Req0 && Req1) begin
            winner_s = ~last_grant_r;
        end else if (Req1) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        if (winner_s) begin
            win_we_s    = We1;
            win_addr_s  = Addr1;
            win_wdata_s = WData1;
        end else begin
            win_we_s    = We0;
            win_addr_s  = Addr0;
            win_wdata_s = WData0;
        end
    end

    // Sequencer FSM together with all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            cur_port_r   <= 1'b0;
            cur_we_r     <= 1'b0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            Address      <= {ADDR_W{1'b0}};
            WriteData    <= {DATA_W{1'b0}};
            Ack0         <= 1'b0;
            Ack1         <= 1'b0;
            RData0       <= {DATA_W{1'b0}};
            RData1       <= {DATA_W{1'b0}};
            Busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        Address      <= win_addr_s;
                        WriteData    <= win_wdata_s;
                        MemWrite     <= win_we_s;
                        MemRead      <= ~win_we_s;
                        last_grant_r <= winner_s;
                        cur_port_r   <= winner_s;
                        cur_we_r     <= win_we_s;
                        Busy         <= 1'b1;
                        state_r      <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // Read data is only valid while MemRead is high, i.e. during this cycle.
                    if (!cur_we_r) begin
                        if (cur_port_r) begin
                            RData1 <= ReadData;
                        end else begin
                            RData0 <= ReadData;
                        end
                    end
                    if (cur_port_r) begin
                        Ack1 <= 1'b1;
                    end else begin
                        Ack0 <= 1'b1;
                    end
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    state_r  <= DONE;
                end
                DONE: begin
                    Ack0    <= 1'b0;
                    Ack1    <= 1'b0;
                    Busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    Ack0     <= 1'b0;
                    Ack1     <= 1'b0;
                    Busy     <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule
